// File: rtl/window_gen_3x3.sv
// Streaming 3x3 neighbourhood generator: two line buffers feed a shifting 3x3 window,
// interior windows are strobed with oDataValid and their min/max follow one cycle later with oEn.
module window_gen_3x3 #(
   parameter int IMG_WIDTH  = 640,
   parameter int IMG_HEIGHT = 480
) (
   input  logic       iClk,
   input  logic       iRst,
   input  logic [7:0] iv8Pixel,
   input  logic       iPixelValid,
   input  logic       iFrameStart,
   output logic [7:0] ov8Pixel_a,
   output logic [7:0] ov8Pixel_b,
   output logic [7:0] ov8Pixel_c,
   output logic [7:0] ov8Pixel_d,
   output logic [7:0] ov8Pixel_fij,
   output logic [7:0] ov8Pixel_e,
   output logic [7:0] ov8Pixel_f,
   output logic [7:0] ov8Pixel_g,
   output logic [7:0] ov8Pixel_h,
   output logic       oDataValid,
   output logic [7:0] ov8Minij,
   output logic [7:0] ov8Maxij,
   output logic       oEn,
   output logic       oFrameDone
);

   localparam int CW = $clog2(IMG_WIDTH);
   localparam int RW = $clog2(IMG_HEIGHT);
   localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
   localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);

   logic [CW-1:0] col_q, col_d, cur_col;
   logic [RW-1:0] row_q, row_d, cur_row;
   logic          frame_sync;
   logic          win_full;
   logic          last_px;

   logic [7:0]    lb1_mem [IMG_WIDTH];
   logic [7:0]    lb2_mem [IMG_WIDTH];
   logic [7:0]    lb1_rd;
   logic [7:0]    lb2_rd;

   // Window slots in raster order: 0=a 1=b 2=c 3=d 4=fij 5=e 6=f 7=g 8=h
   logic [7:0]    win_q [9];
   logic [7:0]    win_d [9];
   logic [7:0]    pix_q [9];
   logic [7:0]    pix_d [9];

   logic          dv_q, dv_d;
   logic          en_q, en_d;
   logic          fd_pend_q, fd_pend_d;
   logic          fd_q, fd_d;
   logic [7:0]    min_q, min_d;
   logic [7:0]    max_q, max_d;
   logic [7:0]    win_min;
   logic [7:0]    win_max;

   // A qualified frame start overrides the counters so the accepted pixel is (0,0).
   always_comb begin
      frame_sync = iPixelValid && iFrameStart;
      cur_col    = frame_sync ? '0 : col_q;
      cur_row    = frame_sync ? '0 : row_q;
      lb1_rd     = lb1_mem[cur_col];
      lb2_rd     = lb2_mem[cur_col];
      win_full   = (cur_row >= RW'(2)) && (cur_col >= CW'(2));
      last_px    = (cur_row == ROW_LAST) && (cur_col == COL_LAST);
   end

   always_comb begin
      col_d = col_q;
      row_d = row_q;
      if (iPixelValid) begin
         if (cur_col == COL_LAST) begin
            col_d = '0;
            row_d = (cur_row == ROW_LAST) ? '0 : cur_row + 1'b1;
         end else begin
            col_d = cur_col + 1'b1;
            row_d = cur_row;
         end
      end
   end

   always_comb begin
      for (int i = 0; i < 9; i++) begin
         win_d[i] = win_q[i];
      end
      if (iPixelValid) begin
         for (int r = 0; r < 3; r++) begin
            win_d[3*r]   = win_q[3*r+1];
            win_d[3*r+1] = win_q[3*r+2];
         end
         win_d[2] = lb2_rd;
         win_d[5] = lb1_rd;
         win_d[8] = iv8Pixel;
      end
   end

   // Presented window only changes when a complete interior window is strobed.
   always_comb begin
      for (int i = 0; i < 9; i++) begin
         pix_d[i] = pix_q[i];
      end
      dv_d = iPixelValid && win_full;
      if (dv_d) begin
         for (int i = 0; i < 9; i++) begin
            pix_d[i] = win_d[i];
         end
      end
      fd_pend_d = dv_d && last_px;
      en_d      = dv_q;
      fd_d      = fd_pend_q;
   end

   always_comb begin
      win_min = pix_q[0];
      win_max = pix_q[0];
      for (int i = 1; i < 9; i++) begin
         if (pix_q[i] < win_min) win_min = pix_q[i];
         if (pix_q[i] > win_max) win_max = pix_q[i];
      end
      min_d = dv_q ? win_min : min_q;
      max_d = dv_q ? win_max : max_q;
   end

   // Line buffers are intentionally unreset; row gating keeps stale rows from ever being emitted.
   always_ff @(posedge iClk) begin
      if (!iRst && iPixelValid) begin
         lb2_mem[cur_col] <= lb1_rd;
         lb1_mem[cur_col] <= iv8Pixel;
      end
   end

   always_ff @(posedge iClk) begin
      if (iRst) begin
         col_q     <= '0;
         row_q     <= '0;
         dv_q      <= 1'b0;
         en_q      <= 1'b0;
         fd_pend_q <= 1'b0;
         fd_q      <= 1'b0;
         min_q     <= '0;
         max_q     <= '0;
         for (int i = 0; i < 9; i++) begin
            win_q[i] <= '0;
            pix_q[i] <= '0;
         end
      end else begin
         col_q     <= col_d;
         row_q     <= row_d;
         dv_q      <= dv_d;
         en_q      <= en_d;
         fd_pend_q <= fd_pend_d;
         fd_q      <= fd_d;
         min_q     <= min_d;
         max_q     <= max_d;
         for (int i = 0; i < 9; i++) begin
            win_q[i] <= win_d[i];
            pix_q[i] <= pix_d[i];
         end
      end
   end

   assign ov8Pixel_a   = pix_q[0];
   assign ov8Pixel_b   = pix_q[1];
   assign ov8Pixel_c   = pix_q[2];
   assign ov8Pixel_d   = pix_q[3];
   assign ov8Pixel_fij = pix_q[4];
   assign ov8Pixel_e   = pix_q[5];
   assign ov8Pixel_f   = pix_q[6];
   assign ov8Pixel_g   = pix_q[7];
   assign ov8Pixel_h   = pix_q[8];
   assign oDataValid   = dv_q;
   assign oEn          = en_q;
   assign oFrameDone   = fd_q;
   assign ov8Minij     = min_q;
   assign ov8Maxij     = max_q;

endmodule

// File: tb/tb_window_gen_3x3.sv
// Self-checking bench for window_gen_3x3 on a 5x4 image: a frame-image model predicts every
// output each cycle, and directed scenarios pin window contents, counts and min/max with literals.
module tb_window_gen_3x3;

   localparam int W = 5;
   localparam int H = 4;
   localparam logic [71:0] FIRST_WIN = {8'd0, 8'd1, 8'd2, 8'd10, 8'd11, 8'd12, 8'd20, 8'd21, 8'd22};
   localparam logic [71:0] LAST_WIN  = {8'd12, 8'd13, 8'd14, 8'd22, 8'd23, 8'd24, 8'd32, 8'd33, 8'd34};

   logic       iClk = 1'b0;
   logic       iRst;
   logic [7:0] iv8Pixel;
   logic       iPixelValid;
   logic       iFrameStart;
   logic [7:0] ov8Pixel_a, ov8Pixel_b, ov8Pixel_c;
   logic [7:0] ov8Pixel_d, ov8Pixel_fij, ov8Pixel_e;
   logic [7:0] ov8Pixel_f, ov8Pixel_g, ov8Pixel_h;
   logic       oDataValid;
   logic [7:0] ov8Minij, ov8Maxij;
   logic       oEn;
   logic       oFrameDone;

   always #5 iClk = ~iClk;

   window_gen_3x3 #(.IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
      .iClk(iClk), .iRst(iRst), .iv8Pixel(iv8Pixel), .iPixelValid(iPixelValid),
      .iFrameStart(iFrameStart),
      .ov8Pixel_a(ov8Pixel_a), .ov8Pixel_b(ov8Pixel_b), .ov8Pixel_c(ov8Pixel_c),
      .ov8Pixel_d(ov8Pixel_d), .ov8Pixel_fij(ov8Pixel_fij), .ov8Pixel_e(ov8Pixel_e),
      .ov8Pixel_f(ov8Pixel_f), .ov8Pixel_g(ov8Pixel_g), .ov8Pixel_h(ov8Pixel_h),
      .oDataValid(oDataValid), .ov8Minij(ov8Minij), .ov8Maxij(ov8Maxij),
      .oEn(oEn), .oFrameDone(oFrameDone)
   );

   int checks = 0;
   int errors = 0;

   // Model state: the image as received so far, plus the outputs expected in the current cycle
   logic [7:0] img [H][W];
   int         mRow, mCol, mR, mC;
   logic       expDv, expEn, expFd, expLastPend;
   logic [7:0] expWin [9];
   logic [7:0] expMin, expMax;
   bit         modelLive = 0;

   logic [71:0] winQ[$];
   logic [15:0] mmQ[$];
   logic [71:0] rampWins[$];
   int          fdCount = 0;

   task automatic checkOutput(input string name, input logic [95:0] act, input logic [95:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic applyStimulus(input logic v, input logic fs, input logic [7:0] px, input logic rst);
      @(negedge iClk);
      iPixelValid = v;
      iFrameStart = fs;
      iv8Pixel    = px;
      iRst        = rst;
   endtask

   function automatic logic [71:0] packExp();
      logic [71:0] p = '0;
      for (int i = 0; i < 9; i++) p = {p[63:0], expWin[i]};
      return p;
   endfunction

   function automatic logic [7:0] pixVal(input int mode, input int r, input int c);
      if (mode == 0) return 8'(10 * r + c);
      if (mode == 1) begin
         if (r == 0 && c == 0) return 8'd0;
         if (r == 1 && c == 1) return 8'd128;
         if (r == 2 && c == 2) return 8'd255;
         return 8'd100;
      end
      return 8'(100 + 10 * r + c);
   endfunction

   // Model: windows are read straight out of the stored image at (r-2..r, c-2..c)
   always @(posedge iClk) begin
      if (iRst) begin
         modelLive = 1;
         mRow = 0; mCol = 0;
         expDv = 0; expEn = 0; expFd = 0; expLastPend = 0;
         expMin = 0; expMax = 0;
         for (int i = 0; i < 9; i++) expWin[i] = 0;
      end else if (modelLive) begin
         expEn = expDv;
         expFd = expDv && expLastPend;
         if (expDv) begin
            expMin = 8'd255;
            expMax = 8'd0;
            for (int i = 0; i < 9; i++) begin
               if (expWin[i] < expMin) expMin = expWin[i];
               if (expWin[i] > expMax) expMax = expWin[i];
            end
         end
         expDv = 0;
         if (iPixelValid) begin
            mR = iFrameStart ? 0 : mRow;
            mC = iFrameStart ? 0 : mCol;
            img[mR][mC] = iv8Pixel;
            if (mR >= 2 && mC >= 2) begin
               expDv = 1;
               expLastPend = (mR == H - 1) && (mC == W - 1);
               for (int dr = 0; dr < 3; dr++)
                  for (int dc = 0; dc < 3; dc++)
                     expWin[dr*3+dc] = img[mR-2+dr][mC-2+dc];
            end
            mC++;
            if (mC == W) begin
               mC = 0;
               mR++;
               if (mR == H) mR = 0;
            end
            mRow = mR;
            mCol = mC;
         end
      end
   end

   // Compare every cycle, also recording what the DUT strobed for the directed literal checks
   always @(negedge iClk) begin
      if (modelLive) begin
         checkOutput("strobes", {93'd0, oDataValid, oEn, oFrameDone}, {93'd0, expDv, expEn, expFd});
         checkOutput("window", {24'd0, ov8Pixel_a, ov8Pixel_b, ov8Pixel_c, ov8Pixel_d, ov8Pixel_fij,
                     ov8Pixel_e, ov8Pixel_f, ov8Pixel_g, ov8Pixel_h}, {24'd0, packExp()});
         checkOutput("minmax", {80'd0, ov8Minij, ov8Maxij}, {80'd0, expMin, expMax});
         if (oDataValid === 1'b1)
            winQ.push_back({ov8Pixel_a, ov8Pixel_b, ov8Pixel_c, ov8Pixel_d, ov8Pixel_fij,
                            ov8Pixel_e, ov8Pixel_f, ov8Pixel_g, ov8Pixel_h});
         if (oEn === 1'b1) mmQ.push_back({ov8Minij, ov8Maxij});
         if (oFrameDone === 1'b1) fdCount++;
      end
   end

   task automatic sendFrame(input int mode, input bit fs, input bit gapped);
      for (int r = 0; r < H; r++)
         for (int c = 0; c < W; c++) begin
            applyStimulus(1'b1, fs && r == 0 && c == 0, pixVal(mode, r, c), 1'b0);
            if (gapped) applyStimulus(1'b0, 1'b0, 8'd0, 1'b0);
         end
   endtask

   task automatic idleAndClear(input int n);
      for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 8'd0, 1'b0);
      winQ.delete();
      mmQ.delete();
      fdCount = 0;
   endtask

   task automatic settle();
      for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b0, 8'd0, 1'b0);
   endtask

   initial begin
      iRst = 1'b1; iPixelValid = 1'b0; iFrameStart = 1'b0; iv8Pixel = 8'd0;
      applyStimulus(1'b0, 1'b0, 8'd0, 1'b1);
      applyStimulus(1'b0, 1'b0, 8'd0, 1'b1);
      applyStimulus(1'b0, 1'b0, 8'd0, 1'b0);
      checkOutput("resetState", {ov8Pixel_a, ov8Pixel_b, ov8Pixel_c, ov8Pixel_d, ov8Pixel_fij,
                  ov8Pixel_e, ov8Pixel_f, ov8Pixel_g, ov8Pixel_h, ov8Minij, ov8Maxij,
                  oDataValid, oEn, oFrameDone, 5'd0}, 96'd0);
      idleAndClear(2);

      $display("[TB] ramp frame");
      sendFrame(0, 1'b1, 1'b0);
      settle();
      checkOutput("rampCount", 96'(winQ.size()), 96'd6);
      checkOutput("rampFirst", {24'd0, winQ[0]}, {24'd0, FIRST_WIN});
      checkOutput("rampFirstMM", {80'd0, mmQ[0]}, {80'd0, 8'd0, 8'd22});
      checkOutput("rampLast", {24'd0, winQ[5]}, {24'd0, LAST_WIN});
      checkOutput("rampLastMM", {80'd0, mmQ[5]}, {80'd0, 8'd12, 8'd34});
      checkOutput("rampFrameDone", 96'(fdCount), 96'd1);
      rampWins = winQ;
      idleAndClear(2);

      $display("[TB] gapped input");
      sendFrame(0, 1'b1, 1'b1);
      settle();
      checkOutput("gapCount", 96'(winQ.size()), 96'd6);
      for (int i = 0; i < 6; i++)
         checkOutput($sformatf("gapWin%0d", i), {24'd0, winQ[i]}, {24'd0, rampWins[i]});
      idleAndClear(2);

      $display("[TB] min/max extremes");
      sendFrame(1, 1'b1, 1'b0);
      settle();
      checkOutput("extremeMM", {80'd0, mmQ[0]}, {80'd0, 8'd0, 8'd255});
      checkOutput("extremeCentre", 96'(winQ[0][39:32]), 96'd128);
      idleAndClear(2);

      $display("[TB] mid-frame resync");
      for (int k = 0; k < 14; k++)
         applyStimulus(1'b1, k == 0, pixVal(2, k / W, k % W), 1'b0);
      sendFrame(0, 1'b1, 1'b0);
      settle();
      checkOutput("resyncCount", 96'(winQ.size()), 96'd8);
      checkOutput("resyncFirstNew", {24'd0, winQ[2]}, {24'd0, FIRST_WIN});
      checkOutput("resyncFrameDone", 96'(fdCount), 96'd1);
      idleAndClear(2);

      $display("[TB] reset mid-stream");
      for (int k = 0; k < 13; k++)
         applyStimulus(1'b1, k == 0, pixVal(0, k / W, k % W), 1'b0);
      applyStimulus(1'b1, 1'b0, 8'd77, 1'b1);
      applyStimulus(1'b0, 1'b0, 8'd0, 1'b0);
      checkOutput("rstZero", {ov8Pixel_a, ov8Pixel_h, ov8Minij, ov8Maxij, oDataValid, oEn,
                  oFrameDone, 61'd0}, 96'd0);
      sendFrame(0, 1'b0, 1'b0);
      settle();
      checkOutput("rstDvCount", 96'(winQ.size()), 96'd7);
      checkOutput("rstEnCount", 96'(mmQ.size()), 96'd6);
      checkOutput("rstFirstNew", {24'd0, winQ[1]}, {24'd0, FIRST_WIN});
      idleAndClear(2);

      $display("[TB] frame wrap");
      sendFrame(0, 1'b1, 1'b0);
      sendFrame(0, 1'b0, 1'b0);
      settle();
      checkOutput("wrapCount", 96'(winQ.size()), 96'd12);
      checkOutput("wrapSecondFirst", {24'd0, winQ[6]}, {24'd0, FIRST_WIN});
      checkOutput("wrapSecondLast", {24'd0, winQ[11]}, {24'd0, LAST_WIN});
      checkOutput("wrapFrameDone", 96'(fdCount), 96'd2);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
